// File: rtl/tinysat_pkg.sv
// Shared types and constants for the tinysat host-side controller.
package tinysat_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_PAD    = 3'd2,
    S_LOAD   = 3'd3,
    S_RUN    = 3'd4,
    S_REPORT = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  // Default core geometry.
  localparam int NUM_BITS         = 4;
  localparam int LOG2_NUM_CLAUSES = 4;
  localparam int NUM_CLAUSES      = 1 << LOG2_NUM_CLAUSES;
  localparam int NUM_LITS         = 3 * NUM_CLAUSES;
  localparam int PAD_LEN          = NUM_CLAUSES;

  // Watchdog defaults: 9-bit cycle counter saturating at 511.
  localparam int DEF_RUN_TIMEOUT  = 320;
  localparam int CYC_W            = 9;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

endpackage

// File: rtl/tinysat_ctrl_if.sv
// Host-facing bundle: job control, literal stream and result record.
//
// Literal stream: a nibble moves on every rising clock edge where
// lit_valid && lit_ready are both high; lit_data must be stable while
// lit_valid is high, and lit_ready never depends combinationally on
// lit_valid. Result record: result_valid stays high with all result_*
// fields frozen until the edge where result_ack is seen high.
interface tinysat_ctrl_if #(
  parameter int NUM_BITS = 4
);
  logic                start;
  logic                abort;
  logic                lit_valid;
  logic [3:0]          lit_data;
  logic                lit_ready;
  logic                busy;
  logic                result_valid;
  logic                result_ack;
  logic                result_sat;
  logic                result_timeout;
  logic [NUM_BITS-1:0] result_x;
  logic [8:0]          result_cycles;

  modport master (
    output start, abort, lit_valid, lit_data, result_ack,
    input  lit_ready, busy, result_valid, result_sat, result_timeout,
           result_x, result_cycles
  );

  modport slave (
    input  start, abort, lit_valid, lit_data, result_ack,
    output lit_ready, busy, result_valid, result_sat, result_timeout,
           result_x, result_cycles
  );
endinterface

// File: rtl/tinysat_watchdog.sv
// Saturating RUN-cycle counter; o_next is the count including the current
// enabled cycle, o_expired flags that this cycle reaches RUN_TIMEOUT.
module tinysat_watchdog #(
  parameter int RUN_TIMEOUT = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [8:0] o_next,
  output logic       o_expired
);
  import tinysat_pkg::*;

  logic [CYC_W-1:0] r_count;
  logic [CYC_W-1:0] w_inc;

  // Saturating increment of the running count.
  always_comb begin
    w_inc = (r_count == CYC_MAX) ? r_count : r_count + 1'b1;
  end

  assign o_next    = w_inc;
  assign o_expired = i_en && (int'(w_inc) >= RUN_TIMEOUT);

  // Counter register: clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_inc;
    end
  end

endmodule

// File: rtl/tinysat_ctrl.sv
// Host-side sequencer for the tinysat solver core: clears the core, pads
// slot 0, streams the host literals in, supervises the search and returns
// a one-shot result record. All outputs come straight from registers.
module tinysat_ctrl #(
  parameter int NUM_BITS         = tinysat_pkg::NUM_BITS,
  parameter int LOG2_NUM_CLAUSES = tinysat_pkg::LOG2_NUM_CLAUSES,
  parameter int RUN_TIMEOUT      = tinysat_pkg::DEF_RUN_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  tinysat_ctrl_if.slave       host,
  output logic                core_reset,
  output logic                core_load,
  output logic                core_run,
  output logic [3:0]          core_data,
  input  logic [NUM_BITS-1:0] core_x,
  input  logic                core_sol,
  input  logic                core_done,
  output tinysat_pkg::state_t dbg_state
);
  import tinysat_pkg::*;

  localparam int L_NUM_CLAUSES = 1 << LOG2_NUM_CLAUSES;
  localparam int L_NUM_LITS    = 3 * L_NUM_CLAUSES;
  localparam int L_PAD_LEN     = L_NUM_CLAUSES;
  localparam int CNT_W         = $clog2(L_NUM_LITS);

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_core_reset, w_core_reset;
  logic                r_core_load, w_core_load;
  logic                r_core_run, w_core_run;
  logic [3:0]          r_core_data, w_core_data;
  logic                r_lit_ready, w_lit_ready;
  logic                r_busy, w_busy;
  logic                r_result_valid, w_result_valid;
  logic                r_result_sat, r_result_timeout;
  logic [NUM_BITS-1:0] r_result_x;
  logic [CYC_W-1:0]    r_result_cycles;
  logic                w_capture, w_cap_sat, w_cap_timeout;
  logic                w_wd_clr, w_wd_en, w_wd_expired;
  logic [CYC_W-1:0]    w_wd_next;

  assign w_wd_clr = (r_state != S_RUN);
  assign w_wd_en  = r_core_run;

  tinysat_watchdog #(
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (reset),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_next    (w_wd_next),
    .o_expired (w_wd_expired)
  );

  // Next state and next registered outputs; abort overrides everything.
  always_comb begin
    w_state        = r_state;
    w_cnt          = r_cnt;
    w_core_reset   = 1'b0;
    w_core_load    = 1'b0;
    w_core_run     = 1'b0;
    w_core_data    = 4'h0;
    w_lit_ready    = 1'b0;
    w_result_valid = 1'b0;
    w_capture      = 1'b0;
    w_cap_sat      = 1'b0;
    w_cap_timeout  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (host.start && !host.abort) begin
          w_state      = S_CLR;
          w_core_reset = 1'b1;
        end
      end
      S_CLR: begin
        w_state     = S_PAD;
        w_cnt       = '0;
        w_core_load = 1'b1;
      end
      S_PAD: begin
        if (r_cnt == CNT_W'(L_PAD_LEN - 1)) begin
          w_state     = S_LOAD;
          w_cnt       = '0;
          w_lit_ready = 1'b1;
        end else begin
          w_cnt       = r_cnt + 1'b1;
          w_core_load = 1'b1;
        end
      end
      S_LOAD: begin
        w_lit_ready = 1'b1;
        if (host.lit_valid && r_lit_ready) begin
          w_core_load = 1'b1;
          w_core_data = host.lit_data;
          if (r_cnt == CNT_W'(L_NUM_LITS - 1)) begin
            w_state     = S_RUN;
            w_lit_ready = 1'b0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      S_RUN: begin
        // The first RUN cycle keeps core_run low so the last core_load
        // pulse never overlaps it.
        w_core_run = 1'b1;
        if (r_core_run && core_done) begin
          w_capture  = 1'b1;
          w_cap_sat  = core_sol;
          w_core_run = 1'b0;
          w_state    = S_REPORT;
        end else if (w_wd_expired) begin
          w_capture     = 1'b1;
          w_cap_timeout = 1'b1;
          w_core_run    = 1'b0;
          w_state       = S_REPORT;
        end
      end
      S_REPORT: begin
        w_result_valid = 1'b1;
        if (r_result_valid && host.result_ack) begin
          w_state        = S_IDLE;
          w_result_valid = 1'b0;
        end
      end
      S_ABORT: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (host.abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
      w_state        = S_ABORT;
      w_core_reset   = 1'b1;
      w_core_load    = 1'b0;
      w_core_run     = 1'b0;
      w_core_data    = 4'h0;
      w_lit_ready    = 1'b0;
      w_result_valid = 1'b0;
      w_capture      = 1'b0;
    end

    w_busy = (w_state != S_IDLE);
  end

  // State, counter and output registers; result fields load only on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_core_reset     <= 1'b1;
      r_core_load      <= 1'b0;
      r_core_run       <= 1'b0;
      r_core_data      <= 4'h0;
      r_lit_ready      <= 1'b0;
      r_busy           <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_sat     <= 1'b0;
      r_result_timeout <= 1'b0;
      r_result_x       <= '0;
      r_result_cycles  <= '0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_core_reset   <= w_core_reset;
      r_core_load    <= w_core_load;
      r_core_run     <= w_core_run;
      r_core_data    <= w_core_data;
      r_lit_ready    <= w_lit_ready;
      r_busy         <= w_busy;
      r_result_valid <= w_result_valid;
      if (w_capture) begin
        r_result_sat     <= w_cap_sat;
        r_result_timeout <= w_cap_timeout;
        r_result_x       <= core_x;
        r_result_cycles  <= w_wd_next;
      end
    end
  end

  assign core_reset          = r_core_reset;
  assign core_load           = r_core_load;
  assign core_run            = r_core_run;
  assign core_data           = r_core_data;
  assign host.lit_ready      = r_lit_ready;
  assign host.busy           = r_busy;
  assign host.result_valid   = r_result_valid;
  assign host.result_sat     = r_result_sat;
  assign host.result_timeout = r_result_timeout;
  assign host.result_x       = r_result_x;
  assign host.result_cycles  = r_result_cycles;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_tinysat_ctrl.sv
// Bench for tinysat_ctrl with a scripted core stub.
module tb_tinysat_ctrl;
  import tinysat_pkg::*;

  localparam int RW = 2 + 4 + 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tinysat_ctrl_if #(.NUM_BITS(4)) if_h ();

  logic       core_reset, core_load, core_run;
  logic [3:0] core_data;
  logic [3:0] core_x;
  logic       core_sol;
  logic       core_done;
  state_t     dbg_state;

  tinysat_ctrl #(
    .NUM_BITS         (4),
    .LOG2_NUM_CLAUSES (4),
    .RUN_TIMEOUT      (320)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (if_h),
    .core_reset (core_reset),
    .core_load  (core_load),
    .core_run   (core_run),
    .core_data  (core_data),
    .core_x     (core_x),
    .core_sol   (core_sol),
    .core_done  (core_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- core stub ----------------
  int         stub_done_after = 0;  // 0 = never finishes
  logic       stub_sol = 1'b0;
  logic [3:0] stub_x = 4'h0;
  int         run_cnt = 0;

  assign core_sol = stub_sol;
  assign core_x   = stub_x;

  always @(posedge clk) begin
    if (reset || core_reset || !core_run) begin
      run_cnt   <= 0;
      core_done <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (stub_done_after != 0 && run_cnt + 1 >= stub_done_after)
        core_done <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0]    exp_load_q[$];
  logic [RW-1:0] exp_res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  logic          prev_rv = 1'b0;
  logic [RW-1:0] held_rec = '0;
  logic [RW-1:0] cur_rec;
  logic [RW-1:0] exp_rec;
  logic [3:0]    exp_nib;

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    cur_rec = {if_h.result_sat, if_h.result_timeout, if_h.result_x, if_h.result_cycles};
    if (core_load || core_run || core_reset) begin
      check("load_run_exclusive", {31'b0, core_load && core_run}, 32'd0);
      if (core_reset)
        check("reset_quiets_core", {30'b0, core_load, core_run}, 32'd0);
    end
    if (core_load) begin
      if (exp_load_q.size() == 0) begin
        fail_now("load_unexpected", int'(core_data), -1);
      end else begin
        exp_nib = exp_load_q.pop_front();
        check("load_data", {28'b0, core_data}, {28'b0, exp_nib});
      end
    end
    if (if_h.result_valid && !prev_rv) begin
      if (exp_res_q.size() == 0) begin
        fail_now("result_unexpected", int'(cur_rec), -1);
      end else begin
        exp_rec = exp_res_q.pop_front();
        check("result_record", {17'b0, cur_rec}, {17'b0, exp_rec});
      end
      held_rec <= cur_rec;
    end else if (if_h.result_valid && prev_rv) begin
      check("result_hold", {17'b0, cur_rec}, {17'b0, held_rec});
    end
    prev_rv <= if_h.result_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic start_job();
    int n;
    @(negedge clk);
    for (int i = 0; i < 16; i++) exp_load_q.push_back(4'h0);
    if_h.start = 1'b1;
    @(posedge clk);
    #1 if_h.start = 1'b0;
    @(negedge clk);
    check("clr_core_reset", {31'b0, core_reset}, 32'd1);
    check("clr_busy", {31'b0, if_h.busy}, 32'd1);
    @(negedge clk);
    check("clr_one_cycle", {31'b0, core_reset}, 32'd0);
    n = 2;
    while (!if_h.lit_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("lit_ready_latency", n, 32'd18);
  endtask

  // Called at a negedge, returns at the negedge after the accepting edge.
  task automatic send_nib(input logic [3:0] d, input int gap);
    int g;
    repeat (gap) @(negedge clk);
    g = 0;
    while (!if_h.lit_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!if_h.lit_ready) begin
      fail_now("lit_ready_wait", 0, 1);
      return;
    end
    if_h.lit_valid = 1'b1;
    if_h.lit_data  = d;
    exp_load_q.push_back(d);
    @(negedge clk);
    if_h.lit_valid = 1'b0;
  endtask

  task automatic run_job(input int done_after, input logic sol, input logic [3:0] x,
                         input int seed, input logic exp_sat, input logic exp_to,
                         input logic [8:0] exp_cycles);
    int n;
    stub_done_after = done_after;
    stub_sol        = sol;
    stub_x          = x;
    start_job();
    for (int i = 0; i < 48; i++)
      send_nib(4'((i * 3 + seed) & 15), $urandom_range(0, 2));
    check("lit_ready_after_last", {31'b0, if_h.lit_ready}, 32'd0);
    exp_res_q.push_back({exp_sat, exp_to, x, exp_cycles});
    n = 0;
    while (!if_h.result_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!if_h.result_valid) begin
      fail_now("result_wait", n, 0);
      return;
    end
    repeat (2) @(negedge clk);
    if_h.start = 1'b1;
    @(negedge clk);
    if_h.start = 1'b0;
    check("report_ignores_start", {30'b0, if_h.busy, if_h.result_valid}, 32'd3);
    repeat (2) @(negedge clk);
    if_h.result_ack = 1'b1;
    @(negedge clk);
    if_h.result_ack = 1'b0;
    check("ack_clears_valid", {30'b0, if_h.busy, if_h.result_valid}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset           = 1'b1;
    if_h.start      = 1'b0;
    if_h.abort      = 1'b0;
    if_h.lit_valid  = 1'b0;
    if_h.lit_data   = 4'h0;
    if_h.result_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_pins", {25'b0, core_reset, core_load, core_run, core_data}, 32'h40);
    check("rst_host_flags", {27'b0, if_h.lit_ready, if_h.busy, if_h.result_valid,
                             if_h.result_sat, if_h.result_timeout}, 32'd0);
    check("rst_result_fields", {19'b0, if_h.result_x, if_h.result_cycles}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("core_reset_release", {31'b0, core_reset}, 32'd0);

    // abort together with start in IDLE: nothing happens
    if_h.start = 1'b1;
    if_h.abort = 1'b1;
    @(negedge clk);
    if_h.start = 1'b0;
    if_h.abort = 1'b0;
    check("idle_abort_start", {30'b0, if_h.busy, core_reset}, 32'd0);

    // reset mid-LOAD after 10 nibbles
    start_job();
    for (int i = 0; i < 10; i++) send_nib(4'(15 - i), 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_core_pins", {25'b0, core_reset, core_load, core_run, core_data}, 32'h40);
    check("midrst_host_flags", {29'b0, if_h.lit_ready, if_h.busy, if_h.result_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_load_q_empty", exp_load_q.size(), 32'd0);

    // SAT: done seen in run cycle 6
    run_job(5, 1'b1, 4'b0001, 1, 1'b1, 1'b0, 9'd6);
    // UNSAT: done seen in run cycle 201
    run_job(200, 1'b0, 4'hA, 7, 1'b0, 1'b0, 9'd201);
    // timeout: core never finishes
    run_job(0, 1'b1, 4'h6, 11, 1'b0, 1'b1, 9'd320);

    // abort on the 20th nibble
    stub_done_after = 1;
    start_job();
    for (int i = 0; i < 19; i++) send_nib(4'(i + 2), $urandom_range(0, 1));
    if_h.lit_valid = 1'b1;
    if_h.lit_data  = 4'h9;
    if_h.abort     = 1'b1;
    @(negedge clk);
    if_h.lit_valid = 1'b0;
    if_h.abort     = 1'b0;
    check("abort_pulse", {29'b0, core_reset, core_load, if_h.busy}, 32'd5);
    @(negedge clk);
    check("abort_idle", {29'b0, core_reset, if_h.busy, if_h.lit_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_load_q_empty", exp_load_q.size(), 32'd0);

    // fresh job after abort, earliest possible done
    run_job(1, 1'b1, 4'h3, 5, 1'b1, 1'b0, 9'd2);

    repeat (3) @(negedge clk);
    check("load_q_empty", exp_load_q.size(), 32'd0);
    check("res_q_empty", exp_res_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Run-time guard
  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
